gemm_result_drain: RTL and testbench

Tail-end result collector for the 1-D systolic GEMM array. It issues the read-output request into the first PE's `i_rd_output` and captures the C_DIM*C_DIM result beats that the last PE emits on its A channel. The results are buffered in an internal FIFO and presented to the user/memory side as a ready/valid stream, with a last flag on the final beat of each matrix. The array side has no backpressure, so the block only requests a readout when a full matrix of buffer space is free.

---
 rtl/gemm_result_drain.sv | 114 +++++++++++
 tb/tb_gemm_result_drain.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_result_drain.sv
// Result drain for the 1-D systolic GEMM array: requests a readout, captures
// C_DIM*C_DIM result beats into a FIFO and streams them out with a last flag.
module gemm_result_drain #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_DIM        = 4,
  parameter int C_FIFO_DEPTH = 32
) (
  input  logic                               clock,
  input  logic                               i_reset_n,
  input  logic                               i_enable,
  output logic                               o_rd_output,
  input  logic [C_DATA_WIDTH-1:0]            i_res_data,
  input  logic                               i_res_valid,
  output logic [C_DATA_WIDTH-1:0]            o_tdata,
  output logic                               o_tvalid,
  output logic                               o_tlast,
  input  logic                               i_tready,
  output logic [$clog2(C_DIM*C_DIM)-1:0]     o_beat_idx,
  output logic                               o_error
);
  localparam int NBEATS = C_DIM * C_DIM;
  localparam int BW     = $clog2(NBEATS);
  localparam int AW     = $clog2(C_FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam logic [BW-1:0] LAST_IDX    = BW'(NBEATS - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(C_FIFO_DEPTH);
  localparam logic [CW-1:0] SPACE_LIMIT = CW'(C_FIFO_DEPTH - NBEATS);

  typedef enum logic [1:0] {IDLE, REQ, COLLECT} state_t;

  // Stream handshake: a beat transfers on any rising edge where o_tvalid and
  // i_tready are both 1; o_tdata/o_tlast hold while o_tvalid & !i_tready.

  state_t                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  error_q, error_d;
  logic                  rd_output_q, rd_output_d;
  logic [C_DATA_WIDTH:0] mem_q [C_FIFO_DEPTH];

  logic          empty, full, pop, push, drop, collecting, last_beat;
  logic [CW-1:0] count_after_pop;

  always_comb begin
    empty           = (count_q == '0);
    full            = (count_q == DEPTH_C);
    pop             = !empty && i_tready;
    collecting      = (state_q == REQ) || (state_q == COLLECT);
    // A pop in the same cycle frees the slot, so a push at full still lands.
    push            = collecting && i_res_valid && (!full || pop);
    drop            = i_res_valid && !push;
    last_beat       = (beat_q == LAST_IDX);
    count_after_pop = count_q - CW'(pop);

    state_d  = state_q;
    beat_d   = beat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    error_d  = error_q || drop;

    case (state_q)
      IDLE:    if (i_enable && (count_after_pop <= SPACE_LIMIT)) state_d = REQ;
      REQ:     if (push) state_d = last_beat ? IDLE : COLLECT;
      COLLECT: if (push && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) begin
      beat_d   = last_beat ? '0 : beat_q + BW'(1);
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    rd_output_d = (state_d == REQ);
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
      rd_output_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      error_q     <= error_d;
      rd_output_q <= rd_output_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is 0.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {last_beat, i_res_data};
  end

  always_comb begin
    o_tvalid    = !empty;
    o_tdata     = empty ? '0 : mem_q[rd_ptr_q][C_DATA_WIDTH-1:0];
    o_tlast     = empty ? 1'b0 : mem_q[rd_ptr_q][C_DATA_WIDTH];
    o_rd_output = rd_output_q;
    o_beat_idx  = beat_q;
    o_error     = error_q;
  end

endmodule

// File: tb/tb_gemm_result_drain.sv
// Bench for gemm_result_drain: randomized result beats checked against a
// queue model of the captured matrix stream.
module tb_gemm_result_drain;
  localparam int W = 32;
  localparam int N = 16;

  logic          clock = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_enable = 1'b0;
  logic          o_rd_output;
  logic [W-1:0]  i_res_data = '0;
  logic          i_res_valid = 1'b0;
  logic [W-1:0]  o_tdata;
  logic          o_tvalid;
  logic          o_tlast;
  logic          i_tready = 1'b0;
  logic [3:0]    o_beat_idx;
  logic          o_error;

  int tests_run = 0;
  int fails = 0;

  // Reference model: expected stream entries {last, data}, capture index, error.
  logic [W:0]    exp_q[$];
  logic [3:0]    model_idx = '0;
  logic          model_err = 1'b0;
  bit            mon_en = 1'b0;

  gemm_result_drain #(.C_DATA_WIDTH(W), .C_DIM(4), .C_FIFO_DEPTH(32)) dut (
    .clock(clock), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .o_rd_output(o_rd_output), .i_res_data(i_res_data),
    .i_res_valid(i_res_valid), .o_tdata(o_tdata), .o_tvalid(o_tvalid),
    .o_tlast(o_tlast), .i_tready(i_tready), .o_beat_idx(o_beat_idx),
    .o_error(o_error)
  );

  always #5 clock = ~clock;

  // Stream monitor: compares the head of the stream with the model each cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      tests_run++;
      if (o_tvalid !== (exp_q.size() != 0)) begin
        fails++;
        $display("FAIL tvalid t=%0t got=%b exp=%b", $time, o_tvalid, exp_q.size() != 0);
      end
      tests_run++;
      if (exp_q.size() != 0) begin
        if ({o_tlast, o_tdata} !== exp_q[0]) begin
          fails++;
          $display("FAIL stream t=%0t got=%h exp=%h", $time, {o_tlast, o_tdata}, exp_q[0]);
        end
        if (i_tready) void'(exp_q.pop_front());
      end else if ({o_tlast, o_tdata} !== '0) begin
        fails++;
        $display("FAIL empty_head t=%0t got=%h exp=0", $time, {o_tlast, o_tdata});
      end
      tests_run++;
      if (o_beat_idx !== model_idx) begin
        fails++;
        $display("FAIL beat_idx t=%0t got=%0d exp=%0d", $time, o_beat_idx, model_idx);
      end
      tests_run++;
      if (o_error !== model_err) begin
        fails++;
        $display("FAIL error t=%0t got=%b exp=%b", $time, o_error, model_err);
      end
    end
  end

  // Raise enable until a readout request appears; cyc = cycles waited or -1.
  task automatic wait_req(output int cyc);
    cyc = -1;
    i_enable = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (o_rd_output === 1'b1) begin
        cyc = i;
        break;
      end
      @(posedge clock); #1;
    end
    i_enable = 1'b0;
  endtask

  // One captured beat; the model gains the entry at the capture edge.
  task automatic drive_beat(input logic [W-1:0] data);
    i_res_valid = 1'b1;
    i_res_data  = data;
    @(posedge clock);
    exp_q.push_back({(model_idx == 4'(N - 1)), data});
    model_idx = model_idx + 4'd1;
    #1;
    i_res_valid = 1'b0;
    i_res_data  = '0;
  endtask

  task automatic drain(input string name);
    i_tready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clock); #1;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain left=%0d exp=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if ({o_rd_output, o_tvalid, o_tlast, o_tdata, o_beat_idx, o_error} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%b/%b/%b/%h/%0d/%b exp=all 0",
               o_rd_output, o_tvalid, o_tlast, o_tdata, o_beat_idx, o_error);
    end
    i_reset_n = 1'b1;
    @(posedge clock); #1;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    int cyc;
    i_tready = 1'b1;
    tests_run++;
    if (o_rd_output !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle_req got=%b exp=0", o_rd_output);
    end
    wait_req(cyc);
    tests_run++;
    if (cyc != 1) begin
      fails++;
      $display("FAIL basic_req_latency got=%0d exp=1", cyc);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      tests_run++;
      if (o_rd_output !== 1'b1) begin
        fails++;
        $display("FAIL basic_req_hold cyc=%0d got=%b exp=1", i, o_rd_output);
      end
    end
    for (int i = 1; i <= N; i++) begin
      drive_beat(W'(i));
      if (i == 1) begin
        tests_run++;
        if (o_rd_output !== 1'b0) begin
          fails++;
          $display("FAIL basic_req_fall got=%b exp=0", o_rd_output);
        end
      end
    end
    drain("basic");
  endtask

  task automatic test_backpressure();
    int cyc;
    bit seen;
    i_tready = 1'b0;
    for (int m = 0; m < 2; m++) begin
      wait_req(cyc);
      tests_run++;
      if (cyc < 0) begin
        fails++;
        $display("FAIL bp_req%0d got=timeout exp=request", m);
      end
      for (int i = 0; i < N; i++) drive_beat($urandom);
    end
    tests_run++;
    if (dut.count_q !== 6'd32) begin
      fails++;
      $display("FAIL bp_count got=%0d exp=32", dut.count_q);
    end
    i_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      tests_run++;
      if (o_rd_output !== 1'b0) begin
        fails++;
        $display("FAIL bp_no_third_req cyc=%0d got=%b exp=0", i, o_rd_output);
      end
    end
    i_tready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clock); #1;
      if (o_rd_output === 1'b1) begin
        seen = 1'b1;
        tests_run++;
        if (dut.count_q > 6'd16) begin
          fails++;
          $display("FAIL bp_req_gate count got=%0d exp<=16", dut.count_q);
        end
      end
    end
    i_enable = 1'b0;
    tests_run++;
    if (!seen) begin
      fails++;
      $display("FAIL bp_req_reassert got=none exp=request");
    end
    for (int i = 0; i < N; i++) drive_beat($urandom);
    drain("bp");
  endtask

  task automatic test_gapped();
    int cyc;
    i_tready = ($urandom_range(0, 1) == 1);
    wait_req(cyc);
    tests_run++;
    if (cyc < 0) begin
      fails++;
      $display("FAIL gap_req got=timeout exp=request");
    end
    for (int i = 0; i < N; i++) begin
      drive_beat($urandom);
      @(posedge clock); #1;
    end
    // Back in IDLE: a fresh enable must produce a request again.
    wait_req(cyc);
    tests_run++;
    if (cyc != 1) begin
      fails++;
      $display("FAIL gap_idle_return got=%0d exp=1", cyc);
    end
    for (int i = 0; i < N; i++) drive_beat($urandom);
    drain("gap");
  endtask

  task automatic test_simultaneous();
    int cyc;
    i_tready = 1'b0;
    wait_req(cyc);
    for (int i = 0; i < N; i++) drive_beat($urandom);
    wait_req(cyc);
    tests_run++;
    if (cyc < 0) begin
      fails++;
      $display("FAIL sim_req got=timeout exp=request");
    end
    for (int i = 0; i < 4; i++) drive_beat($urandom);
    i_tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_beat($urandom);
      tests_run++;
      if (dut.count_q !== 6'd20) begin
        fails++;
        $display("FAIL sim_count beat=%0d got=%0d exp=20", i, dut.count_q);
      end
    end
    drain("sim");
  endtask

  task automatic test_unexpected();
    int cyc;
    i_tready = 1'b1;
    i_enable = 1'b0;
    i_res_valid = 1'b1;
    i_res_data  = 32'hDEAD;
    @(posedge clock);
    model_err = 1'b1;
    #1;
    i_res_valid = 1'b0;
    i_res_data  = '0;
    tests_run++;
    if (o_tvalid !== 1'b0 || o_error !== 1'b1) begin
      fails++;
      $display("FAIL unexp_beat got tvalid=%b error=%b exp tvalid=0 error=1", o_tvalid, o_error);
    end
    wait_req(cyc);
    for (int i = 0; i < N; i++) drive_beat($urandom);
    drain("unexp");
  endtask

  task automatic test_reset_mid();
    int cyc;
    i_tready = 1'b0;
    wait_req(cyc);
    for (int i = 0; i < 7; i++) drive_beat($urandom);
    #2;
    mon_en = 1'b0;
    i_reset_n = 1'b0;
    #1;
    tests_run++;
    if ({o_rd_output, o_tvalid, o_tlast, o_tdata, o_beat_idx, o_error} !== '0) begin
      fails++;
      $display("FAIL rstmid_outputs got=%b/%b/%b/%h/%0d/%b exp=all 0",
               o_rd_output, o_tvalid, o_tlast, o_tdata, o_beat_idx, o_error);
    end
    exp_q.delete();
    model_idx = '0;
    model_err = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    i_reset_n = 1'b1;
    mon_en = 1'b1;
    i_tready = 1'b1;
    wait_req(cyc);
    tests_run++;
    if (cyc < 0) begin
      fails++;
      $display("FAIL rstmid_req got=timeout exp=request");
    end
    for (int i = 0; i < N; i++) drive_beat($urandom);
    drain("rstmid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_simultaneous();
    test_unexpected();
    test_reset_mid();
    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
